// File: rtl/gate_sweep_pkg.sv
// Shared types and elaboration helpers for the gate sweep controller.
// Holds the sequencer state encoding and parameter legality checks.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic bit n_in_legal(input int n_in);
        return (n_in >= 1) && (n_in <= 4);
    endfunction

    function automatic bit settle_legal(input int settle_cycles);
        return settle_cycles >= 1;
    endfunction

endpackage

// File: rtl/gate_sweep_if.sv
// Control/result bundle between the test master and the sweep controller.
// The master issues start/abort with a truth table; the controller returns results.
interface gate_sweep_if #(
    parameter int N_IN = 2
);
    import gate_sweep_pkg::*;

    localparam int NUM_VEC = num_vec(N_IN);

    logic               start;
    logic               abort;
    logic [NUM_VEC-1:0] expected;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] observed;
    logic [N_IN:0]      fail_count;
    logic [N_IN-1:0]    first_fail_idx;

    modport master (
        output start, abort, expected,
        input  busy, done, pass, observed, fail_count, first_fail_idx
    );

    modport slave (
        input  start, abort, expected,
        output busy, done, pass, observed, fail_count, first_fail_idx
    );

endinterface

// File: rtl/gate_sweep_controller_settle_timer.sv
// Loadable down-counter that times how long each vector is held on the cell.
// Counts down to zero and stops; expire_o flags the drained state.
module gate_settle_timer #(
    parameter int LOAD_VAL = 2,
    parameter int W        = $clog2(LOAD_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    output logic [W-1:0] value_o,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = W'(LOAD_VAL);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o  = count_q;
    assign expire_o = (count_q == '0);

endmodule

// File: rtl/gate_sweep_controller.sv
// Walks every input vector of a combinational cell, lets it settle, samples the
// output and scores it against the latched truth table.
module gate_sweep_controller
    import gate_sweep_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    gate_sweep_if.slave     bus,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out
);

    localparam int NUM_VEC = num_vec(N_IN);
    localparam int TW      = $clog2(SETTLE_CYCLES + 1);

    if (!n_in_legal(N_IN) || !settle_legal(SETTLE_CYCLES)) begin : g_param_check
        $error("gate_sweep_controller: N_IN must be 1..4 and SETTLE_CYCLES >= 1");
    end

    sweep_state_e       state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [NUM_VEC-1:0] exp_q, exp_d;
    logic [NUM_VEC-1:0] obs_q, obs_d;
    logic [N_IN:0]      fail_q, fail_d;
    logic [N_IN-1:0]    first_q, first_d;
    logic               pass_q, pass_d;
    logic               settle_load;
    logic [TW-1:0]      settle_value;
    logic               settle_expire;

    gate_settle_timer #(
        .LOAD_VAL (SETTLE_CYCLES),
        .W        (TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (settle_load),
        .value_o  (settle_value),
        .expire_o (settle_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exp_d       = exp_q;
        obs_d       = obs_q;
        fail_d      = fail_q;
        first_d     = first_q;
        pass_d      = pass_q;
        settle_load = 1'b0;

        // Abort overrides everything outside IDLE; partial results are kept.
        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d     = ST_SETTLE;
                        exp_d       = bus.expected;
                        obs_d       = '0;
                        fail_d      = '0;
                        first_d     = '0;
                        pass_d      = 1'b0;
                        idx_d       = '0;
                        settle_load = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_value == TW'(1)) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (settle_expire) begin
                        // Case inequality so an X/Z response scores as a mismatch.
                        obs_d[idx_q] = (dut_out === 1'b1);
                        if (dut_out !== exp_q[idx_q]) begin
                            fail_d = fail_q + 1'b1;
                            if (fail_q == '0) begin
                                first_d = idx_q;
                            end
                        end
                        if (idx_q == N_IN'(NUM_VEC - 1)) begin
                            state_d = ST_DONE;
                            pass_d  = (fail_d == '0);
                        end else begin
                            state_d     = ST_SETTLE;
                            idx_d       = idx_q + 1'b1;
                            settle_load = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            fail_q  <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_in             = idx_q;
    assign bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = pass_q;
    assign bus.observed       = obs_q;
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_idx = first_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Randomised sweeps of an XNOR cell (2 inputs) and an AND cell (3 inputs),
// scored against a truth-table reference model held in the bench.
module tb_gate_sweep_controller;

    localparam int S2 = 2;
    localparam int S3 = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dut_in2;
    logic       dut_out2;
    logic [2:0] dut_in3;
    logic       dut_out3;
    bit         z_mode;

    int nvec;
    int nerr;

    gate_sweep_if #(.N_IN(2)) bus2 ();
    gate_sweep_if #(.N_IN(3)) bus3 ();

    gate_sweep_controller #(.N_IN(2), .SETTLE_CYCLES(S2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .dut_in  (dut_in2),
        .dut_out (dut_out2)
    );

    gate_sweep_controller #(.N_IN(3), .SETTLE_CYCLES(S3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus3),
        .dut_in  (dut_in3),
        .dut_out (dut_out3)
    );

    // Cells under test: 2-input XNOR (optionally floating) and 3-input AND.
    always_comb dut_out2 = z_mode ? 1'bz : (dut_in2[1] ~^ dut_in2[0]);
    always_comb dut_out3 = &dut_in3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: XNOR is 1 when both inputs agree; a floating cell yields Z.
    task automatic model2(input logic [3:0] e, output logic [3:0] obs,
                          output int fc, output int ff);
        logic v;
        obs = '0; fc = 0; ff = 0;
        for (int i = 0; i < 4; i++) begin
            v = z_mode ? 1'bz : logic'(i[1] == i[0]);
            obs[i] = (v === 1'b1);
            if (v !== e[i]) begin
                if (fc == 0) ff = i;
                fc++;
            end
        end
    endtask

    task automatic model3(input logic [7:0] e, output logic [7:0] obs,
                          output int fc, output int ff);
        logic v;
        obs = '0; fc = 0; ff = 0;
        for (int i = 0; i < 8; i++) begin
            v = (i == 7);
            obs[i] = v;
            if (v !== e[i]) begin
                if (fc == 0) ff = i;
                fc++;
            end
        end
    endtask

    task automatic run_sweep2(input logic [3:0] e);
        logic [3:0] m_obs;
        int m_fc, m_ff, cyc;
        bit got_done;
        model2(e, m_obs, m_fc, m_ff);
        bus2.expected = e;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        cyc = 1;
        got_done = 1'b0;
        while (!got_done && cyc < 40) begin
            if (bus2.done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                nvec++;
                if (dut_in2 !== 2'((cyc - 1) / (S2 + 1)) || bus2.busy !== 1'b1) begin
                    nerr++;
                    $display("FAIL sweep2_hold cyc=%0d: dut_in=%0d busy=%b, required dut_in=%0d busy=1",
                             cyc, dut_in2, bus2.busy, (cyc - 1) / (S2 + 1));
                end
                tick();
                cyc++;
            end
        end
        nvec++;
        if (!got_done || cyc != 1 + 4 * (S2 + 1)) begin
            nerr++;
            $display("FAIL sweep2_done_cycle: got %0d (seen=%b), required %0d", cyc, got_done, 1 + 4 * (S2 + 1));
        end
        nvec++;
        if (bus2.pass !== (m_fc == 0) || bus2.observed !== m_obs ||
            bus2.fail_count !== 3'(m_fc) || bus2.first_fail_idx !== 2'(m_ff)) begin
            nerr++;
            $display("FAIL sweep2_result exp=%b z=%b: pass=%b obs=%b fc=%0d ff=%0d, required pass=%b obs=%b fc=%0d ff=%0d",
                     e, z_mode, bus2.pass, bus2.observed, bus2.fail_count, bus2.first_fail_idx,
                     (m_fc == 0), m_obs, m_fc, m_ff);
        end
        $display("sweep2 exp=%b z=%b pass=%b obs=%b fc=%0d ff=%0d", e, z_mode, bus2.pass,
                 bus2.observed, bus2.fail_count, bus2.first_fail_idx);
        tick();
        nvec++;
        if (bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
            nerr++;
            $display("FAIL sweep2_done_width: done=%b busy=%b, required 0 0", bus2.done, bus2.busy);
        end
    endtask

    task automatic run_sweep3(input logic [7:0] e);
        logic [7:0] m_obs;
        int m_fc, m_ff, cyc;
        model3(e, m_obs, m_fc, m_ff);
        bus3.expected = e;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        cyc = 1;
        while (bus3.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        nvec++;
        if (cyc != 41) begin
            nerr++;
            $display("FAIL sweep3_done_cycle: got %0d, required 41", cyc);
        end
        nvec++;
        if (bus3.pass !== (m_fc == 0) || bus3.observed !== m_obs ||
            bus3.fail_count !== 4'(m_fc) || bus3.first_fail_idx !== 3'(m_ff)) begin
            nerr++;
            $display("FAIL sweep3_result exp=%h: pass=%b obs=%h fc=%0d ff=%0d, required pass=%b obs=%h fc=%0d ff=%0d",
                     e, bus3.pass, bus3.observed, bus3.fail_count, bus3.first_fail_idx,
                     (m_fc == 0), m_obs, m_fc, m_ff);
        end
        $display("sweep3 exp=%h pass=%b fc=%0d ff=%0d", e, bus3.pass, bus3.fail_count, bus3.first_fail_idx);
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        nvec++;
        if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.pass !== 1'b0 || dut_in2 !== 2'd0 ||
            bus2.observed !== 4'd0 || bus2.fail_count !== 3'd0 || bus2.first_fail_idx !== 2'd0) begin
            nerr++;
            $display("FAIL %s: busy=%b done=%b pass=%b dut_in=%0d obs=%b fc=%0d ff=%0d, required all 0",
                     tag, bus2.busy, bus2.done, bus2.pass, dut_in2, bus2.observed,
                     bus2.fail_count, bus2.first_fail_idx);
        end
        $display("%s checked", tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("reset_values");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        z_mode = 1'b0;
        run_sweep2(4'b1001);
        run_sweep2(4'b0110);
        z_mode = 1'b1;
        run_sweep2(4'b1001);
        z_mode = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            z_mode = ($urandom_range(0, 3) == 0);
            run_sweep2(4'($urandom_range(0, 15)));
        end
        z_mode = 1'b0;
    endtask

    task automatic test_abort();
        int cyc;
        bus2.expected = 4'b1001;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (4) tick();
        bus2.abort = 1'b1;
        bus2.start = 1'b1;
        tick();
        bus2.abort = 1'b0;
        bus2.start = 1'b0;
        nvec++;
        if (bus2.busy !== 1'b0 || dut_in2 !== 2'd0 || bus2.done !== 1'b0 || bus2.pass !== 1'b0 ||
            bus2.observed !== 4'b0001 || bus2.fail_count !== 3'd0) begin
            nerr++;
            $display("FAIL abort_state: busy=%b dut_in=%0d done=%b pass=%b obs=%b fc=%0d, required 0 0 0 0 0001 0",
                     bus2.busy, dut_in2, bus2.done, bus2.pass, bus2.observed, bus2.fail_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            nvec++;
            if (bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
                nerr++;
                $display("FAIL abort_quiet: done=%b busy=%b, required 0 0", bus2.done, bus2.busy);
            end
        end
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        cyc = 9;
        while (bus2.done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        nvec++;
        if (cyc != 21 || bus2.pass !== 1'b1) begin
            nerr++;
            $display("FAIL abort_restart: done cycle %0d pass=%b, required 21 1", cyc, bus2.pass);
        end
        $display("abort restart done at cycle %0d", cyc);
        tick();
        bus2.abort = 1'b1;
        bus2.start = 1'b1;
        tick();
        bus2.abort = 1'b0;
        bus2.start = 1'b0;
        tick();
        nvec++;
        if (bus2.busy !== 1'b0 || bus2.pass !== 1'b1 || bus2.observed !== 4'b1001) begin
            nerr++;
            $display("FAIL abort_idle: busy=%b pass=%b obs=%b, required 0 1 1001",
                     bus2.busy, bus2.pass, bus2.observed);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int dn;
        int dcyc[3];
        bus2.expected = 4'b0110;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (6) tick();
        nvec++;
        if (bus2.fail_count !== 3'd2 || bus2.busy !== 1'b1) begin
            nerr++;
            $display("FAIL midsweep_partial: fc=%0d busy=%b, required 2 1", bus2.fail_count, bus2.busy);
        end
        rst = 1'b1;
        tick();
        check_reset_values("midsweep_reset");
        rst = 1'b0;
        bus2.expected = 4'b1001;
        bus2.start = 1'b1;
        cyc = 8;
        dn = 0;
        while (dn < 3 && cyc < 120) begin
            tick();
            cyc++;
            if (bus2.done === 1'b1) begin
                dcyc[dn] = cyc;
                dn++;
                nvec++;
                if (bus2.pass !== 1'b1) begin
                    nerr++;
                    $display("FAIL b2b_pass: sweep %0d pass=%b, required 1", dn, bus2.pass);
                end
            end
        end
        bus2.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (i >= dn || dcyc[i] != 21 + 14 * i) begin
                nerr++;
                $display("FAIL b2b_done_cycle %0d: got %0d (count %0d), required %0d",
                         i, (i < dn) ? dcyc[i] : -1, dn, 21 + 14 * i);
            end else begin
                $display("b2b done %0d at cycle %0d", i, dcyc[i]);
            end
        end
        tick();
        tick();
        nvec++;
        if (bus2.busy !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_stop: busy=%b, required 0", bus2.busy);
        end
    endtask

    task automatic test_and3();
        run_sweep3(8'h80);
        run_sweep3(8'h88);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        z_mode = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.expected = '0;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.expected = '0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_and3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
